// File: rtl/apb_slave_regbank_if.sv
// APB completer-side bus bundle: master drives select/enable/address/data,
// slave returns read data, ready and error.
interface apb_slave_regbank_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave_regbank.sv
// APB register bank: read-only ID word at offset 0, read/write registers above it,
// programmable wait states and error response for bad accesses.
//
// state  | meaning
// S_IDLE | waiting for a setup phase; latches address, direction and error
// S_WAIT | access phase, counting down wait states
// S_DONE | pready=1, transfer completes (and write commits) on next psel&penable
module apb_slave_regbank #(
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic                      hclk,
    input  logic                      hresetn,
    apb_slave_regbank_if.slave        apb,
    output logic [32*NUM_REGS-1:0]    reg_q
);

    localparam int unsigned IDXW = $clog2(NUM_REGS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic [IDXW-1:0] r_idx;
    logic            r_write;
    logic            r_err;
    logic [31:0]     r_prdata;
    logic            r_pready;
    logic            r_pslverr;
    logic [31:0]     r_regs [NUM_REGS];

    logic [IDXW-1:0] w_idx;
    logic            w_err;
    logic [31:0]     w_rd_now;
    logic [31:0]     w_rd_lat;

    assign w_idx = apb.paddr[2 +: IDXW];
    assign w_err = (apb.paddr[1:0] != 2'b00)
                || (apb.paddr >= 32'(4 * NUM_REGS))
                || (apb.pwrite && (w_idx == '0));

    // Slot 0 is never written; the ID constant is substituted on read.
    always_comb begin
        w_rd_now = (w_idx == '0) ? ID_VALUE : r_regs[w_idx];
        w_rd_lat = (r_idx == '0) ? ID_VALUE : r_regs[r_idx];
    end

    assign apb.prdata  = r_prdata;
    assign apb.pready  = r_pready;
    assign apb.pslverr = r_pslverr;

    assign reg_q[31:0] = ID_VALUE;
    for (genvar g = 1; g < NUM_REGS; g++) begin : g_regq
        assign reg_q[32*g +: 32] = r_regs[g];
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_write   <= 1'b0;
            r_err     <= 1'b0;
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (apb.psel && !apb.penable) begin
                        r_idx   <= w_idx;
                        r_write <= apb.pwrite;
                        r_err   <= w_err;
                        if (WAIT_CYCLES == 0) begin
                            r_state   <= S_DONE;
                            r_pready  <= 1'b1;
                            r_pslverr <= w_err;
                            r_prdata  <= (w_err || apb.pwrite) ? '0 : w_rd_now;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (!apb.psel) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (apb.penable) begin
                        if (r_cnt == 4'd0) begin
                            r_state   <= S_DONE;
                            r_pready  <= 1'b1;
                            r_pslverr <= r_err;
                            r_prdata  <= (r_err || r_write) ? '0 : w_rd_lat;
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (!apb.psel || apb.penable) begin
                        // pwdata is taken at this edge, not at setup.
                        if (apb.psel && r_write && !r_err) begin
                            r_regs[r_idx] <= apb.pwdata;
                        end
                        r_state   <= S_IDLE;
                        r_pready  <= 1'b0;
                        r_pslverr <= 1'b0;
                        r_prdata  <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Bench for apb_slave_regbank: three instances (0, 3 and 2 wait states) share one
// driven bus, psel steered to one of them; a transaction-level model checks every cycle.
module tb_apb_slave_regbank;

    localparam int          NR  = 8;
    localparam logic [31:0] ID  = 32'hA5B0_0001;
    localparam int          WC [3] = '{0, 3, 2};

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    int          sel = 0;

    always #5 hclk = ~hclk;

    apb_slave_regbank_if bus0 ();
    apb_slave_regbank_if bus1 ();
    apb_slave_regbank_if bus2 ();

    assign bus0.psel = psel && (sel == 0);
    assign bus1.psel = psel && (sel == 1);
    assign bus2.psel = psel && (sel == 2);
    assign bus0.penable = penable; assign bus1.penable = penable; assign bus2.penable = penable;
    assign bus0.pwrite  = pwrite;  assign bus1.pwrite  = pwrite;  assign bus2.pwrite  = pwrite;
    assign bus0.paddr   = paddr;   assign bus1.paddr   = paddr;   assign bus2.paddr   = paddr;
    assign bus0.pwdata  = pwdata;  assign bus1.pwdata  = pwdata;  assign bus2.pwdata  = pwdata;

    logic [32*NR-1:0] q0, q1, q2;

    apb_slave_regbank #(.NUM_REGS(NR), .WAIT_CYCLES(0), .ID_VALUE(ID)) dut0 (
        .hclk(hclk), .hresetn(hresetn), .apb(bus0), .reg_q(q0));
    apb_slave_regbank #(.NUM_REGS(NR), .WAIT_CYCLES(3), .ID_VALUE(ID)) dut1 (
        .hclk(hclk), .hresetn(hresetn), .apb(bus1), .reg_q(q1));
    apb_slave_regbank #(.NUM_REGS(NR), .WAIT_CYCLES(2), .ID_VALUE(ID)) dut2 (
        .hclk(hclk), .hresetn(hresetn), .apb(bus2), .reg_q(q2));

    logic             rdy_a [3];
    logic             err_a [3];
    logic [31:0]      rd_a  [3];
    logic [32*NR-1:0] q_a   [3];
    assign rdy_a[0] = bus0.pready;  assign rdy_a[1] = bus1.pready;  assign rdy_a[2] = bus2.pready;
    assign err_a[0] = bus0.pslverr; assign err_a[1] = bus1.pslverr; assign err_a[2] = bus2.pslverr;
    assign rd_a[0]  = bus0.prdata;  assign rd_a[1]  = bus1.prdata;  assign rd_a[2]  = bus2.prdata;
    assign q_a[0] = q0; assign q_a[1] = q1; assign q_a[2] = q2;

    // Model: register contents per instance plus the expectation for the active transfer
    logic [31:0] m_regs [3][NR];
    int          act = -1;
    logic        exp_rdy = 1'b0;
    logic [31:0] exp_rd = '0;
    logic        exp_err = 1'b0;
    bit          chk_en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    function automatic logic [32*NR-1:0] mflat(input int k);
        logic [32*NR-1:0] f;
        f[31:0] = ID;
        for (int i = 1; i < NR; i++) f[32*i +: 32] = m_regs[k][i];
        return f;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < NR; i++) m_regs[k][i] = '0;
    endtask

    always @(negedge hclk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("pready%0d", k), 256'(rdy_a[k]), 256'((k == act) ? exp_rdy : 1'b0));
                if (k == act && exp_rdy) begin
                    chk($sformatf("prdata%0d", k), 256'(rd_a[k]), 256'(exp_rd));
                    chk($sformatf("pslverr%0d", k), 256'(err_a[k]), 256'(exp_err));
                end
                chk($sformatf("reg_q%0d", k), 256'(q_a[k]), 256'(mflat(k)));
            end
        end
    end

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    // mode: 0 normal, 1 change paddr/pwdata in access phase, 2 drop psel after one
    // access cycle, 3 reset while pready=1
    task automatic xfer(input int k, input logic [31:0] addr, input logic wr,
                        input logic [31:0] data, input int mode,
                        output logic [31:0] rd, output logic er);
        int          idx;
        logic        m_err;
        logic [31:0] m_rd;
        idx   = int'(addr[4:2]);
        m_err = (addr % 4 != 0) || (addr >= 4 * NR) || (wr && addr < 4);
        m_rd  = (m_err || wr) ? 32'h0 : ((idx == 0) ? ID : m_regs[k][idx]);
        rd = '0;
        er = 1'b0;
        sel = k; psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = data;
        act = k; exp_rdy = 1'b0;
        tick();
        penable = 1'b1;
        if (mode == 1) begin
            paddr  = addr ^ 32'h4;
            pwdata = ~data;
        end
        for (int j = 1; j <= WC[k] + 1; j++) begin
            if (mode == 2 && j == 2) begin
                psel = 1'b0; penable = 1'b0; exp_rdy = 1'b0;
                tick();
                tick();
                act = -1;
                return;
            end
            exp_rdy = (j == WC[k] + 1);
            exp_rd  = m_rd;
            exp_err = m_err;
            @(negedge hclk);
            if (exp_rdy) begin
                rd = rd_a[k];
                er = err_a[k];
            end
            if (exp_rdy && mode == 3) begin
                #1;
                hresetn = 1'b0;
                model_reset();
                act = -1; exp_rdy = 1'b0; psel = 1'b0; penable = 1'b0;
                @(posedge hclk);
                @(negedge hclk);
                #1;
                hresetn = 1'b1;
                tick();
                return;
            end
            tick();
        end
        if (wr && !m_err) m_regs[k][idx] = pwdata;
        act = -1; exp_rdy = 1'b0;
    endtask

    task automatic idle();
        psel = 1'b0; penable = 1'b0;
        tick();
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        model_reset();
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        hresetn = 1'b1;
        tick();

        chk("rst_pready", 256'(bus0.pready), 256'(1'b0));
        chk("rst_prdata", 256'(bus0.prdata), 256'(32'h0));
        chk("rst_pslverr", 256'(bus2.pslverr), 256'(1'b0));
        chk("rst_reg_q", 256'(q1), {224'h0, 32'hA5B0_0001});
        chk_en = 1'b1;

        // zero wait states: write then read
        xfer(0, 32'h04, 1'b1, 32'h1234_5678, 0, rd, er);
        chk("w04_err", 256'(er), 256'(1'b0));
        xfer(0, 32'h04, 1'b0, 32'h0, 0, rd, er);
        chk("r04_data", 256'(rd), 256'(32'h1234_5678));
        idle();

        // three wait states: ID read
        xfer(1, 32'h00, 1'b0, 32'h0, 0, rd, er);
        chk("id_read", 256'(rd), 256'(32'hA5B0_0001));
        idle();

        // error writes: read-only, misaligned, out of range; plus an out-of-range read
        xfer(0, 32'h00, 1'b1, 32'hFFFF_FFFF, 0, rd, er);
        chk("err_w00", 256'(er), 256'(1'b1));
        xfer(0, 32'h06, 1'b1, 32'hFFFF_FFFF, 0, rd, er);
        chk("err_w06", 256'(er), 256'(1'b1));
        xfer(0, 32'h20, 1'b1, 32'hFFFF_FFFF, 0, rd, er);
        chk("err_w20", 256'(er), 256'(1'b1));
        xfer(1, 32'h24, 1'b0, 32'h0, 0, rd, er);
        chk("err_r24", 256'({er, rd}), 256'({1'b1, 32'h0}));
        chk("err_regq", 256'(q0[63:32]), 256'(32'h1234_5678));
        idle();

        // back-to-back, no idle cycles
        xfer(0, 32'h08, 1'b1, 32'hCAFE_0008, 0, rd, er);
        xfer(0, 32'h08, 1'b0, 32'h0, 0, rd, er);
        chk("b2b_read", 256'(rd), 256'(32'hCAFE_0008));
        xfer(0, 32'h0C, 1'b1, 32'hBEEF_000C, 0, rd, er);
        idle();
        chk("b2b_regq", 256'(q0[127:96]), 256'(32'hBEEF_000C));

        // penable without setup is ignored
        sel = 0; psel = 1'b1; penable = 1'b1; paddr = 32'h04; pwrite = 1'b0;
        act = 0; exp_rdy = 1'b0;
        tick();
        tick();
        act = -1;
        idle();

        // access-phase address change ignored; pwdata taken at commit
        xfer(0, 32'h10, 1'b1, 32'h0F0F_0000, 1, rd, er);
        idle();
        xfer(0, 32'h10, 1'b0, 32'h0, 0, rd, er);
        chk("late_data", 256'(rd), 256'(32'hF0F0_FFFF));
        xfer(0, 32'h14, 1'b0, 32'h0, 0, rd, er);
        chk("late_addr", 256'(rd), 256'(32'h0));
        idle();

        // two wait states: abort and mid-transfer reset
        xfer(2, 32'h04, 1'b1, 32'h1111_1111, 0, rd, er);
        xfer(2, 32'h04, 1'b1, 32'hDEAD_BEEF, 2, rd, er);
        chk("abort_pready", 256'(bus2.pready), 256'(1'b0));
        chk("abort_regq", 256'(q2[63:32]), 256'(32'h1111_1111));
        xfer(2, 32'h08, 1'b1, 32'h2222_2222, 3, rd, er);
        chk("rst_mid_pready", 256'(bus2.pready), 256'(1'b0));
        for (int i = 1; i < NR; i++) begin
            xfer(2, 32'(4 * i), 1'b0, 32'h0, 0, rd, er);
            chk($sformatf("post_rst_r%0d", i), 256'(rd), 256'(32'h0));
        end
        idle();
        xfer(2, 32'h00, 1'b0, 32'h0, 0, rd, er);
        chk("post_rst_id", 256'(rd), 256'(32'hA5B0_0001));
        idle();
        idle();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
